// File: rtl/systolic_tile_scheduler.sv
// -----------------------------------------------------------------------------
// systolic_tile_scheduler
//
// Purpose:
//   Breaks one (8*M_TILES) x K x (8*N_TILES) matrix multiply into a row-major
//   sequence of 8x8 output tiles. Each tile is issued to the single-tile
//   systolic core, and the scheduler waits for its response before it issues
//   the next one. A single job response reports the tile count. A job with any
//   zero dimension gets an error response and issues no tiles.
//
// Ports:
//   clock, reset              single clock, synchronous active-high reset
//   job_*                     host job command (valid/ready + operands)
//   job_resp_*                job completion (valid/ready, tile count, error)
//   tile_cmd_*                per-tile command to the core (valid/ready)
//   tile_resp_valid/ready     per-tile completion from the core
// -----------------------------------------------------------------------------
module systolic_tile_scheduler #(
  parameter int ADDR_W     = 64,
  parameter int DIM_W      = 20,
  parameter int TCNT_W     = 16,
  parameter int ROW_BYTES  = 16,
  parameter int TILE_BYTES = 128
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  job_valid,
  output logic                  job_ready,
  input  logic [ADDR_W-1:0]     job_act_base,
  input  logic [ADDR_W-1:0]     job_wgt_base,
  input  logic [ADDR_W-1:0]     job_out_base,
  input  logic [DIM_W-1:0]      job_inner_dimension,
  input  logic [TCNT_W-1:0]     job_m_tiles,
  input  logic [TCNT_W-1:0]     job_n_tiles,
  output logic                  job_resp_valid,
  input  logic                  job_resp_ready,
  output logic [2*TCNT_W-1:0]   job_resp_tiles,
  output logic                  job_resp_err,
  output logic                  tile_cmd_valid,
  input  logic                  tile_cmd_ready,
  output logic [ADDR_W-1:0]     tile_cmd_act_addr,
  output logic [ADDR_W-1:0]     tile_cmd_wgt_addr,
  output logic [ADDR_W-1:0]     tile_cmd_out_addr,
  output logic [DIM_W-1:0]      tile_cmd_inner_dimension,
  input  logic                  tile_resp_valid,
  output logic                  tile_resp_ready
);

  // ROW_BYTES is a power of two, so the K-step stride is a plain shift.
  localparam int ROW_SHIFT = $clog2(ROW_BYTES);
  localparam logic [TCNT_W-1:0] CNT_ONE = TCNT_W'(1);
  localparam logic [ADDR_W-1:0] TILE_STEP = ADDR_W'(TILE_BYTES);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t                state_reg, state_next;
  logic [ADDR_W-1:0]     act_ptr_reg, act_ptr_next;
  logic [ADDR_W-1:0]     wgt_ptr_reg, wgt_ptr_next;
  logic [ADDR_W-1:0]     out_ptr_reg, out_ptr_next;
  logic [ADDR_W-1:0]     wgt_base_reg, wgt_base_next;
  logic [ADDR_W-1:0]     act_stride_reg, act_stride_next;
  logic [ADDR_W-1:0]     wgt_stride_reg, wgt_stride_next;
  logic [DIM_W-1:0]      k_reg, k_next;
  logic [TCNT_W-1:0]     m_reg, m_next;
  logic [TCNT_W-1:0]     n_reg, n_next;
  logic [TCNT_W-1:0]     i_reg, i_next;
  logic [TCNT_W-1:0]     j_reg, j_next;
  logic [2*TCNT_W-1:0]   done_cnt_reg, done_cnt_next;
  logic                  err_reg, err_next;

  logic [ADDR_W-1:0]     job_stride;
  logic                  job_zero;
  logic                  last_col;
  logic                  last_tile;

  assign job_stride = ADDR_W'(job_inner_dimension) << ROW_SHIFT;
  assign job_zero   = (job_m_tiles == '0) || (job_n_tiles == '0) ||
                      (job_inner_dimension == '0);
  assign last_col   = (j_reg == n_reg - CNT_ONE);
  assign last_tile  = last_col && (i_reg == m_reg - CNT_ONE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= IDLE;
      act_ptr_reg    <= '0;
      wgt_ptr_reg    <= '0;
      out_ptr_reg    <= '0;
      wgt_base_reg   <= '0;
      act_stride_reg <= '0;
      wgt_stride_reg <= '0;
      k_reg          <= '0;
      m_reg          <= '0;
      n_reg          <= '0;
      i_reg          <= '0;
      j_reg          <= '0;
      done_cnt_reg   <= '0;
      err_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      act_ptr_reg    <= act_ptr_next;
      wgt_ptr_reg    <= wgt_ptr_next;
      out_ptr_reg    <= out_ptr_next;
      wgt_base_reg   <= wgt_base_next;
      act_stride_reg <= act_stride_next;
      wgt_stride_reg <= wgt_stride_next;
      k_reg          <= k_next;
      m_reg          <= m_next;
      n_reg          <= n_next;
      i_reg          <= i_next;
      j_reg          <= j_next;
      done_cnt_reg   <= done_cnt_next;
      err_reg        <= err_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    act_ptr_next    = act_ptr_reg;
    wgt_ptr_next    = wgt_ptr_reg;
    out_ptr_next    = out_ptr_reg;
    wgt_base_next   = wgt_base_reg;
    act_stride_next = act_stride_reg;
    wgt_stride_next = wgt_stride_reg;
    k_next          = k_reg;
    m_next          = m_reg;
    n_next          = n_reg;
    i_next          = i_reg;
    j_next          = j_reg;
    done_cnt_next   = done_cnt_reg;
    err_next        = err_reg;

    job_ready       = 1'b0;
    tile_cmd_valid  = 1'b0;
    tile_resp_ready = 1'b0;
    job_resp_valid  = 1'b0;

    case (state_reg)
      IDLE: begin
        job_ready = 1'b1;
        if (job_valid) begin
          act_ptr_next    = job_act_base;
          wgt_ptr_next    = job_wgt_base;
          out_ptr_next    = job_out_base;
          wgt_base_next   = job_wgt_base;
          act_stride_next = job_stride;
          wgt_stride_next = job_stride;
          k_next          = job_inner_dimension;
          m_next          = job_m_tiles;
          n_next          = job_n_tiles;
          i_next          = '0;
          j_next          = '0;
          done_cnt_next   = '0;
          err_next        = job_zero;
          state_next      = job_zero ? DONE : ISSUE;
        end
      end

      ISSUE: begin
        tile_cmd_valid = 1'b1;
        if (tile_cmd_ready) state_next = WAIT;
      end

      WAIT: begin
        tile_resp_ready = 1'b1;
        if (tile_resp_valid) begin
          done_cnt_next = done_cnt_reg + 1'b1;
          out_ptr_next  = out_ptr_reg + TILE_STEP;
          if (last_col) begin
            // End of a tile row: next activation slice, weights restart.
            j_next       = '0;
            i_next       = i_reg + CNT_ONE;
            act_ptr_next = act_ptr_reg + act_stride_reg;
            wgt_ptr_next = wgt_base_reg;
          end else begin
            j_next       = j_reg + CNT_ONE;
            wgt_ptr_next = wgt_ptr_reg + wgt_stride_reg;
          end
          state_next = last_tile ? DONE : ISSUE;
        end
      end

      DONE: begin
        job_resp_valid = 1'b1;
        if (job_resp_ready) state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  assign tile_cmd_act_addr        = act_ptr_reg;
  assign tile_cmd_wgt_addr        = wgt_ptr_reg;
  assign tile_cmd_out_addr        = out_ptr_reg;
  assign tile_cmd_inner_dimension = k_reg;
  assign job_resp_tiles           = done_cnt_reg;
  assign job_resp_err             = err_reg;

endmodule

// File: tb/tb_systolic_tile_scheduler.sv
// -----------------------------------------------------------------------------
// tb_systolic_tile_scheduler
//
// Directed bench for systolic_tile_scheduler. Inputs change and outputs are
// sampled on the falling edge; the DUT acts on the rising edge.
// -----------------------------------------------------------------------------
module tb_systolic_tile_scheduler;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          job_valid = 1'b0;
  logic          job_ready;
  logic [63:0]   job_act_base = '0;
  logic [63:0]   job_wgt_base = '0;
  logic [63:0]   job_out_base = '0;
  logic [19:0]   job_inner_dimension = '0;
  logic [15:0]   job_m_tiles = '0;
  logic [15:0]   job_n_tiles = '0;
  logic          job_resp_valid;
  logic          job_resp_ready = 1'b0;
  logic [31:0]   job_resp_tiles;
  logic          job_resp_err;
  logic          tile_cmd_valid;
  logic          tile_cmd_ready = 1'b0;
  logic [63:0]   tile_cmd_act_addr;
  logic [63:0]   tile_cmd_wgt_addr;
  logic [63:0]   tile_cmd_out_addr;
  logic [19:0]   tile_cmd_inner_dimension;
  logic          tile_resp_valid = 1'b0;
  logic          tile_resp_ready;

  int checks = 0;
  int fails  = 0;

  always #5 clock = ~clock;

  systolic_tile_scheduler dut (
    .clock                    (clock),
    .reset                    (reset),
    .job_valid                (job_valid),
    .job_ready                (job_ready),
    .job_act_base             (job_act_base),
    .job_wgt_base             (job_wgt_base),
    .job_out_base             (job_out_base),
    .job_inner_dimension      (job_inner_dimension),
    .job_m_tiles              (job_m_tiles),
    .job_n_tiles              (job_n_tiles),
    .job_resp_valid           (job_resp_valid),
    .job_resp_ready           (job_resp_ready),
    .job_resp_tiles           (job_resp_tiles),
    .job_resp_err             (job_resp_err),
    .tile_cmd_valid           (tile_cmd_valid),
    .tile_cmd_ready           (tile_cmd_ready),
    .tile_cmd_act_addr        (tile_cmd_act_addr),
    .tile_cmd_wgt_addr        (tile_cmd_wgt_addr),
    .tile_cmd_out_addr        (tile_cmd_out_addr),
    .tile_cmd_inner_dimension (tile_cmd_inner_dimension),
    .tile_resp_valid          (tile_resp_valid),
    .tile_resp_ready          (tile_resp_ready)
  );

  // Present a job for one cycle; it fires on the rising edge in between.
  task automatic send_job(input logic [63:0] act, input logic [63:0] wgt,
                          input logic [63:0] outb, input logic [19:0] k,
                          input logic [15:0] m, input logic [15:0] n);
    @(negedge clock);
    job_act_base = act;
    job_wgt_base = wgt;
    job_out_base = outb;
    job_inner_dimension = k;
    job_m_tiles = m;
    job_n_tiles = n;
    job_valid = 1'b1;
    @(negedge clock);
    job_valid = 1'b0;
  endtask

  // Wait (bounded) until a tile command is presented; capture its fields.
  task automatic wait_cmd(output bit ok, output logic [63:0] act,
                          output logic [63:0] wgt, output logic [63:0] outa,
                          output logic [19:0] k);
    ok = 1'b0; act = '0; wgt = '0; outa = '0; k = '0;
    for (int c = 0; c < 50; c++) begin
      if (tile_cmd_valid) begin
        ok = 1'b1;
        act = tile_cmd_act_addr;
        wgt = tile_cmd_wgt_addr;
        outa = tile_cmd_out_addr;
        k = tile_cmd_inner_dimension;
        break;
      end
      @(negedge clock);
    end
  endtask

  // Core model: accept the pending command, then answer after lat cycles.
  task automatic core_serve(input int lat);
    tile_cmd_ready = 1'b1;
    @(negedge clock);
    tile_cmd_ready = 1'b0;
    repeat (lat) @(negedge clock);
    tile_resp_valid = 1'b1;
    @(negedge clock);
    tile_resp_valid = 1'b0;
  endtask

  // Wait (bounded) for the job response; capture it and acknowledge.
  task automatic wait_resp(output bit ok, output logic [31:0] tiles,
                           output logic err);
    ok = 1'b0; tiles = '0; err = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (job_resp_valid) begin
        ok = 1'b1;
        tiles = job_resp_tiles;
        err = job_resp_err;
        break;
      end
      @(negedge clock);
    end
    if (ok) begin
      job_resp_ready = 1'b1;
      @(negedge clock);
      job_resp_ready = 1'b0;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if ({job_ready, tile_cmd_valid, job_resp_valid, tile_resp_ready} !== 4'b1000) begin
      fails++;
      $display("FAIL reset_handshakes got %b want 1000",
               {job_ready, tile_cmd_valid, job_resp_valid, tile_resp_ready});
    end
    checks++;
    if (tile_cmd_act_addr !== 64'h0 || tile_cmd_out_addr !== 64'h0 ||
        job_resp_tiles !== 32'h0 || job_resp_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_regs got act=%h out=%h tiles=%0d err=%b want zeros",
               tile_cmd_act_addr, tile_cmd_out_addr, job_resp_tiles, job_resp_err);
    end
    reset = 1'b0;
    @(negedge clock);
    $display("reset done: job_ready=%b", job_ready);
  endtask

  task automatic test_single;
    bit ok; logic [63:0] a, w, o; logic [19:0] k; logic [31:0] t; logic e;
    send_job(64'h1000, 64'h8000, 64'h20000, 20'd4, 16'd1, 16'd1);
    wait_cmd(ok, a, w, o, k);
    checks++;
    if (!ok || a !== 64'h1000 || w !== 64'h8000 || o !== 64'h20000 || k !== 20'd4) begin
      fails++;
      $display("FAIL single_cmd got ok=%b act=%h wgt=%h out=%h k=%0d want 1000 8000 20000 4",
               ok, a, w, o, k);
    end
    $display("single: tile act=%h wgt=%h out=%h k=%0d", a, w, o, k);
    if (ok) core_serve(0);
    wait_resp(ok, t, e);
    checks++;
    if (!ok || t !== 32'd1 || e !== 1'b0) begin
      fails++;
      $display("FAIL single_resp got ok=%b tiles=%0d err=%b want tiles=1 err=0", ok, t, e);
    end
    checks++;
    if (job_ready !== 1'b1 || job_resp_valid !== 1'b0) begin
      fails++;
      $display("FAIL single_idle got job_ready=%b resp_valid=%b want 1 0",
               job_ready, job_resp_valid);
    end
    $display("single: resp tiles=%0d err=%b", t, e);
  endtask

  task automatic test_multi;
    bit ok; logic [63:0] a, w, o; logic [19:0] k; logic [31:0] t; logic e;
    logic [63:0] exp_act [6] = '{64'h1000, 64'h1000, 64'h1000, 64'h1040, 64'h1040, 64'h1040};
    logic [63:0] exp_wgt [6] = '{64'h8000, 64'h8040, 64'h8080, 64'h8000, 64'h8040, 64'h8080};
    logic [63:0] exp_out [6] = '{64'h20000, 64'h20080, 64'h20100, 64'h20180, 64'h20200, 64'h20280};
    send_job(64'h1000, 64'h8000, 64'h20000, 20'd4, 16'd2, 16'd3);
    for (int n = 0; n < 6; n++) begin
      wait_cmd(ok, a, w, o, k);
      checks++;
      if (!ok || a !== exp_act[n] || w !== exp_wgt[n] || o !== exp_out[n] || k !== 20'd4) begin
        fails++;
        $display("FAIL multi_cmd%0d got ok=%b act=%h wgt=%h out=%h k=%0d want %h %h %h 4",
                 n, ok, a, w, o, k, exp_act[n], exp_wgt[n], exp_out[n]);
      end
      $display("multi: tile %0d act=%h wgt=%h out=%h", n, a, w, o);
      if (!ok) break;
      core_serve(n % 3);
    end
    wait_resp(ok, t, e);
    checks++;
    if (!ok || t !== 32'd6 || e !== 1'b0) begin
      fails++;
      $display("FAIL multi_resp got ok=%b tiles=%0d err=%b want tiles=6 err=0", ok, t, e);
    end
    $display("multi: resp tiles=%0d err=%b", t, e);
  endtask

  task automatic test_zero_dims;
    logic [19:0] ks [3] = '{20'd4, 20'd4, 20'd0};
    logic [15:0] ms [3] = '{16'd0, 16'd2, 16'd2};
    logic [15:0] ns [3] = '{16'd3, 16'd0, 16'd3};
    for (int c = 0; c < 3; c++) begin
      send_job(64'h1000, 64'h8000, 64'h20000, ks[c], ms[c], ns[c]);
      // Fire happened on the edge just passed: response is already visible.
      checks++;
      if (job_resp_valid !== 1'b1 || job_resp_err !== 1'b1 || job_resp_tiles !== 32'd0 ||
          tile_cmd_valid !== 1'b0 || job_ready !== 1'b0) begin
        fails++;
        $display("FAIL zero%0d got rv=%b err=%b tiles=%0d cv=%b jr=%b want 1 1 0 0 0",
                 c, job_resp_valid, job_resp_err, job_resp_tiles, tile_cmd_valid, job_ready);
      end
      job_resp_ready = 1'b1;
      @(negedge clock);
      job_resp_ready = 1'b0;
      checks++;
      if (job_ready !== 1'b1 || tile_cmd_valid !== 1'b0 || job_resp_valid !== 1'b0) begin
        fails++;
        $display("FAIL zero%0d_idle got jr=%b cv=%b rv=%b want 1 0 0",
                 c, job_ready, tile_cmd_valid, job_resp_valid);
      end
      $display("zero case %0d: k=%0d m=%0d n=%0d rejected", c, ks[c], ms[c], ns[c]);
    end
  endtask

  task automatic test_back_pressure;
    bit ok; logic [63:0] a, w, o; logic [19:0] k;
    send_job(64'h3000, 64'h5000, 64'h7000, 20'd2, 16'd1, 16'd1);
    wait_cmd(ok, a, w, o, k);
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      checks++;
      if (!ok || tile_cmd_valid !== 1'b1 || tile_cmd_act_addr !== 64'h3000 ||
          tile_cmd_wgt_addr !== 64'h5000 || tile_cmd_out_addr !== 64'h7000 ||
          tile_cmd_inner_dimension !== 20'd2 || job_ready !== 1'b0) begin
        fails++;
        $display("FAIL stall_cmd%0d got v=%b act=%h wgt=%h out=%h k=%0d jr=%b want 1 3000 5000 7000 2 0",
                 c, tile_cmd_valid, tile_cmd_act_addr, tile_cmd_wgt_addr,
                 tile_cmd_out_addr, tile_cmd_inner_dimension, job_ready);
      end
    end
    core_serve(1);
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (job_resp_valid !== 1'b1 || job_resp_tiles !== 32'd1 || job_resp_err !== 1'b0 ||
          job_ready !== 1'b0) begin
        fails++;
        $display("FAIL stall_resp%0d got rv=%b tiles=%0d err=%b jr=%b want 1 1 0 0",
                 c, job_resp_valid, job_resp_tiles, job_resp_err, job_ready);
      end
      @(negedge clock);
    end
    job_resp_ready = 1'b1;
    @(negedge clock);
    job_resp_ready = 1'b0;
    checks++;
    if (job_ready !== 1'b1 || job_resp_valid !== 1'b0) begin
      fails++;
      $display("FAIL stall_release got jr=%b rv=%b want 1 0", job_ready, job_resp_valid);
    end
    $display("back-pressure: 5 cmd stall cycles, 3 resp stall cycles held");
  endtask

  task automatic test_resp_in_issue;
    bit ok; logic [63:0] a, w, o; logic [19:0] k; logic [31:0] t; logic e;
    send_job(64'h1000, 64'h8000, 64'h20000, 20'd4, 16'd1, 16'd2);
    wait_cmd(ok, a, w, o, k);
    tile_resp_valid = 1'b1;
    checks++;
    if (!ok || tile_resp_ready !== 1'b0) begin
      fails++;
      $display("FAIL issue_resp_ready got ok=%b ready=%b want 0", ok, tile_resp_ready);
    end
    @(negedge clock);
    tile_resp_valid = 1'b0;
    checks++;
    if (tile_cmd_valid !== 1'b1 || tile_cmd_out_addr !== 64'h20000 ||
        tile_cmd_wgt_addr !== 64'h8000) begin
      fails++;
      $display("FAIL issue_resp_ignored got v=%b out=%h wgt=%h want 1 20000 8000",
               tile_cmd_valid, tile_cmd_out_addr, tile_cmd_wgt_addr);
    end
    core_serve(0);
    wait_cmd(ok, a, w, o, k);
    checks++;
    if (!ok || a !== 64'h1000 || w !== 64'h8040 || o !== 64'h20080) begin
      fails++;
      $display("FAIL issue_second got ok=%b act=%h wgt=%h out=%h want 1000 8040 20080",
               ok, a, w, o);
    end
    if (ok) core_serve(0);
    wait_resp(ok, t, e);
    checks++;
    if (!ok || t !== 32'd2 || e !== 1'b0) begin
      fails++;
      $display("FAIL issue_resp got ok=%b tiles=%0d err=%b want 2 0", ok, t, e);
    end
    $display("resp-in-issue: ignored, job tiles=%0d", t);
  endtask

  task automatic test_wrap;
    bit ok; logic [63:0] a, w, o; logic [19:0] k; logic [31:0] t; logic e;
    send_job(64'hFFFF_FFFF_FFFF_FFF0, 64'h100, 64'hFFFF_FFFF_FFFF_FFC0, 20'd1, 16'd2, 16'd1);
    wait_cmd(ok, a, w, o, k);
    if (ok) core_serve(0);
    wait_cmd(ok, a, w, o, k);
    checks++;
    if (!ok || a !== 64'h0 || w !== 64'h100 || o !== 64'h40) begin
      fails++;
      $display("FAIL wrap_cmd got ok=%b act=%h wgt=%h out=%h want 0 100 40", ok, a, w, o);
    end
    if (ok) core_serve(0);
    wait_resp(ok, t, e);
    checks++;
    if (!ok || t !== 32'd2) begin
      fails++;
      $display("FAIL wrap_resp got ok=%b tiles=%0d want 2", ok, t);
    end
    $display("wrap: second tile act=%h out=%h", a, o);
  endtask

  task automatic test_reset_mid;
    bit ok; logic [63:0] a, w, o; logic [19:0] k; logic [31:0] t; logic e;
    send_job(64'h1000, 64'h8000, 64'h20000, 20'd4, 16'd2, 16'd2);
    wait_cmd(ok, a, w, o, k);
    if (ok) core_serve(0);
    wait_cmd(ok, a, w, o, k);
    tile_cmd_ready = 1'b1;
    @(negedge clock);
    tile_cmd_ready = 1'b0;
    checks++;
    if (!ok || tile_resp_ready !== 1'b1) begin
      fails++;
      $display("FAIL mid_in_wait got ok=%b resp_ready=%b want 1", ok, tile_resp_ready);
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checks++;
    if ({job_ready, tile_cmd_valid, job_resp_valid, tile_resp_ready} !== 4'b1000) begin
      fails++;
      $display("FAIL mid_reset got %b want 1000",
               {job_ready, tile_cmd_valid, job_resp_valid, tile_resp_ready});
    end
    send_job(64'hA000, 64'hB000, 64'hC000, 20'd3, 16'd1, 16'd1);
    wait_cmd(ok, a, w, o, k);
    checks++;
    if (!ok || a !== 64'hA000 || w !== 64'hB000 || o !== 64'hC000 || k !== 20'd3) begin
      fails++;
      $display("FAIL mid_fresh_cmd got ok=%b act=%h wgt=%h out=%h k=%0d want A000 B000 C000 3",
               ok, a, w, o, k);
    end
    if (ok) core_serve(2);
    wait_resp(ok, t, e);
    checks++;
    if (!ok || t !== 32'd1 || e !== 1'b0) begin
      fails++;
      $display("FAIL mid_fresh_resp got ok=%b tiles=%0d err=%b want 1 0", ok, t, e);
    end
    $display("reset-mid: fresh job tiles=%0d err=%b", t, e);
  endtask

  initial begin
    test_reset;
    test_single;
    test_multi;
    test_zero_dims;
    test_back_pressure;
    test_resp_in_issue;
    test_wrap;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
